ram_stream_fifo_ctrl: RTL

- Synchronous FIFO controller that sits directly in front of the team's 64x8 dual-port RAM and drives both of its ports.
- Accepts a valid/ready byte stream on the ingress side and writes it into the RAM through port A.
- Reads the stored bytes back through port B and presents them in order on a valid/ready egress stream.
- A 2-entry output skid buffer hides the RAM's 1-cycle registered read latency, so a continuously-ready consumer gets one byte per cycle.

---
 rtl/ram_stream_fifo_ctrl.sv | 68 ++++++
 1 files changed

// File: rtl/ram_stream_fifo_ctrl.sv
// ram_stream_fifo_ctrl: valid/ready byte FIFO built around an external 64x8 dual-port RAM,
// with a 2-entry skid buffer that hides the RAM's registered read latency.
module ram_stream_fifo_ctrl #(
   parameter int DW = 8,
   parameter int AW = 6,
   parameter int DEPTH = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] ram_addr_a,
   output logic [DW-1:0] ram_data_a,
   output logic          ram_we_a,
   output logic [AW-1:0] ram_addr_b,
   output logic [DW-1:0] ram_data_b,
   output logic          ram_we_b,
   input  logic [DW-1:0] ram_q_b,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [DW-1:0] buf0, buf1, head_s;
   logic [1:0]    buf_cnt, cnt_s, occ;
   logic          inflight, push, pop, issue;
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign in_ready = !full;
   assign push = in_valid & in_ready;
   assign out_valid = buf_cnt != 2'd0;
   assign out_data = buf0;
   assign pop = out_valid & out_ready;
   // Issue only while the buffer plus the pending return leaves room for one more byte.
   assign occ = buf_cnt + {1'b0, inflight} - {1'b0, pop};
   assign issue = !empty & (occ < 2'd2);
   assign cnt_s = buf_cnt - {1'b0, pop};
   assign head_s = pop ? buf1 : buf0;
   assign ram_we_a = push;
   assign ram_addr_a = wr_ptr;
   assign ram_data_a = in_data;
   assign ram_addr_b = rd_ptr;
   assign ram_data_b = '0;
   assign ram_we_b = 1'b0;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         inflight <= 1'b0;
         buf_cnt <= 2'd0;
         buf0 <= '0;
         buf1 <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(issue);
         level <= level + (AW+1)'(push) - (AW+1)'(issue);
         inflight <= issue;
         buf_cnt <= cnt_s + {1'b0, inflight};
         buf0 <= (inflight && cnt_s == 2'd0) ? ram_q_b : head_s;
         buf1 <= (inflight && cnt_s != 2'd0) ? ram_q_b : buf1;
      end
   end
endmodule
